sd_cmd_tx: RTL and testbench
============================

Name: sd_cmd_tx

Overview:
Host-side SD command transmitter, the outbound counterpart of the response receiver on the CMD line. It accepts a command index and a 32-bit argument and builds the 48-bit command frame: start bit 0, transmission bit 1, 6-bit index, 32-bit argument, serially computed CRC7, end bit 1. It shifts the frame MSB-first onto sd_cmd under a programmable bit period, then enforces an Ncc inter-command gap before reporting completion to the host controller FSM.

Parameters:
CLK_DIV, 2, clk cycles per CMD bit period; legal range 1..255.
NCC, 8, idle bit periods with sd_cmd released after the end bit, before sd_send_finished.

Ports:
clk  input  1  single block clock; all state changes on posedge.
reset  input  1  reset; asynchronous, active-low (0 = reset).
send_en  input  1  start request; sampled only in IDLE.
cmd_index  input  6  command index; captured on accept.
argument  input  32  command argument; captured on accept.
sd_cmd_out  output  1  serial CMD data, MSB first.
sd_cmd_oe  output  1  CMD line drive enable; 1 = host drives sd_cmd_out.
busy  output  1  high from the cycle after accept through the sd_send_finished cycle inclusive.
sd_send_finished  output  1  one-cycle pulse when the frame and the Ncc gap are complete.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, sd_cmd_out=1, sd_cmd_oe=0, busy=0, sd_send_finished=0, CRC=0, all counters=0. A reset during a frame aborts it immediately. No finished pulse is produced, and the line is released in the same cycle.
- FSM states: IDLE, SEND, CRC, STOP, GAP.
- IDLE: sd_cmd_oe=0, sd_cmd_out=1. On posedge with send_en=1:
  - capture the frame {1'b0, 1'b1, cmd_index, argument} into a 40-bit shift register;
  - clear the CRC to 0 and the bit counter to 39;
  - go to SEND.
  - send_en is ignored in every other state; a held send_en does not retrigger until IDLE is re-entered.
- Bit timing: each bit is held on sd_cmd_out for exactly CLK_DIV clk cycles, counted by a divide counter. A bit advances when the divide counter reaches CLK_DIV-1. The first bit (start bit 0) appears in the cycle after accept.
- SEND (40 bits, frame bits 47..8):
  - sd_cmd_oe=1, sd_cmd_out = shift register MSB.
  - At each bit advance, update the CRC with the outgoing bit d: fb = d ^ crc[6]; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00). Polynomial is x^7+x^3+1.
  - After bit 0 of the counter, go to CRC.
- CRC (7 bits, frame bits 7..1): sd_cmd_oe=1; shift crc[6:0] out MSB-first. The CRC is not updated in this state. Then go to STOP.
- STOP (1 bit, frame bit 0): sd_cmd_oe=1, sd_cmd_out=1 for one bit period, then go to GAP.
- GAP: sd_cmd_oe=0, sd_cmd_out=1 for NCC bit periods. On the final cycle of the gap, assert sd_send_finished for one cycle, deassert busy on the following cycle, and return to IDLE.
- Latency:
  - the first frame bit starts 1 cycle after accept;
  - sd_cmd_oe is high for exactly 48*CLK_DIV cycles;
  - sd_send_finished fires at cycle (48+NCC)*CLK_DIV after accept, where the accept edge is cycle 0.
- A new send_en may be accepted in the cycle immediately after sd_send_finished.
- Input changes after accept have no effect on the frame in flight.
- Counters: the bit counter is 6 bits and the divide counter is 8 bits. Neither may wrap within a frame.
- CLK_DIV=1 must work, with one bit per cycle and no idle cycles between bits.

Test Plan:
- CMD0, arg 0x00000000, CLK_DIV=2 -> sd_cmd frame 0x400000000095 (CRC7 0x4A), each bit held 2 cycles. sd_cmd_oe high for 96 cycles. sd_send_finished pulses at cycle 112 after accept.
- CMD8, arg 0x000001AA, CLK_DIV=1 -> frame 0x48000001AA87 (CRC7 0x43) on consecutive cycles. busy drops 1 cycle after finished.
- CMD17, arg 0x00000000 -> frame 0x510000000055 (CRC7 0x2A). Change cmd_index/argument mid-frame -> transmitted frame is unchanged.
- send_en held high for 200 cycles -> exactly one frame per IDLE visit. Back-to-back frames are separated by the NCC gap with sd_cmd_oe=0, sd_cmd_out=1.
- Assert reset low at bit 20 of a frame -> in the same cycle sd_cmd_oe=0, sd_cmd_out=1, busy=0, and no sd_send_finished. After release, a new CMD0 produces the correct 0x95 trailer, confirming the CRC was cleared.
- Random index and argument, 500 frames -> the CRC field matches a reference CRC7 model over bits 47..8, and the end bit is always 1.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD host command transmitter: frames index+argument with CRC7, shifts it MSB-first
// onto the CMD line at CLK_DIV clocks per bit, then holds an Ncc released gap.
module sd_cmd_tx #(
    parameter int CLK_DIV = 2,
    parameter int NCC     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_en,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        sd_send_finished
);
    typedef enum logic [2:0] {IDLE, SEND, CRC, STOP, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_PEN  = (CLK_DIV >= 2) ? 8'(CLK_DIV - 2) : 8'd0;
    localparam logic [5:0] GAP_LAST = 6'(NCC - 1);
    localparam bit         ONE_CYC  = (CLK_DIV == 1);
    localparam bit         ONE_GAP  = (NCC == 1);

    state_t      state;
    logic [39:0] shreg;
    logic [6:0]  crc;
    logic [6:0]  crc_nxt;
    logic [5:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic        tick;
    logic        fb;

    assign tick    = (div_cnt == DIV_LAST);
    assign fb      = shreg[39] ^ crc[6];
    assign crc_nxt = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);

    // Outputs are registered with the state, so each branch sets the value the
    // line must carry in the cycle that follows the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            shreg            <= '0;
            crc              <= '0;
            bit_cnt          <= '0;
            div_cnt          <= '0;
            sd_cmd_out       <= 1'b1;
            sd_cmd_oe        <= 1'b0;
            busy             <= 1'b0;
            sd_send_finished <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sd_cmd_oe        <= 1'b0;
                    sd_cmd_out       <= 1'b1;
                    busy             <= 1'b0;
                    sd_send_finished <= 1'b0;
                    div_cnt          <= '0;
                    if (send_en) begin
                        shreg      <= {2'b01, cmd_index, argument};
                        crc        <= '0;
                        bit_cnt    <= 6'd39;
                        state      <= SEND;
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (tick) begin
                        div_cnt <= '0;
                        crc     <= crc_nxt;
                        shreg   <= {shreg[38:0], 1'b0};
                        if (bit_cnt == 6'd0) begin
                            state      <= CRC;
                            bit_cnt    <= 6'd6;
                            sd_cmd_out <= crc_nxt[6];
                        end else begin
                            bit_cnt    <= bit_cnt - 6'd1;
                            sd_cmd_out <= shreg[38];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                CRC: begin
                    // CRC is read by index, not shifted, so it stays intact here.
                    if (tick) begin
                        div_cnt <= '0;
                        if (bit_cnt == 6'd0) begin
                            state      <= STOP;
                            sd_cmd_out <= 1'b1;
                        end else begin
                            bit_cnt    <= bit_cnt - 6'd1;
                            sd_cmd_out <= crc[bit_cnt[2:0] - 3'd1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        div_cnt          <= '0;
                        state            <= GAP;
                        sd_cmd_oe        <= 1'b0;
                        sd_cmd_out       <= 1'b1;
                        bit_cnt          <= GAP_LAST;
                        sd_send_finished <= ONE_CYC && ONE_GAP;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    // Finished is raised on the edge entering the last gap cycle.
                    if (tick) begin
                        div_cnt <= '0;
                        if (bit_cnt == 6'd0) begin
                            state            <= IDLE;
                            busy             <= 1'b0;
                            sd_send_finished <= 1'b0;
                        end else begin
                            bit_cnt          <= bit_cnt - 6'd1;
                            sd_send_finished <= ONE_CYC && (bit_cnt == 6'd1);
                        end
                    end else begin
                        div_cnt          <= div_cnt + 8'd1;
                        sd_send_finished <= (bit_cnt == 6'd0) && (div_cnt == DIV_PEN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Scoreboard bench for sd_cmd_tx: one instance at CLK_DIV=2, one at CLK_DIV=1.
module tb_sd_cmd_tx;
    localparam int NCC = 8;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] send_en;
    logic [5:0] idx [2];
    logic [31:0] arg [2];
    wire  [1:0] out, oe, busy, fin;

    int checks = 0;
    int failures = 0;
    logic [47:0] q0[$];
    logic [47:0] q1[$];

    always #5 clk = ~clk;

    sd_cmd_tx #(.CLK_DIV(2), .NCC(NCC)) u_div2 (
        .clk(clk), .reset(rst[0]), .send_en(send_en[0]), .cmd_index(idx[0]),
        .argument(arg[0]), .sd_cmd_out(out[0]), .sd_cmd_oe(oe[0]),
        .busy(busy[0]), .sd_send_finished(fin[0]));

    sd_cmd_tx #(.CLK_DIV(1), .NCC(NCC)) u_div1 (
        .clk(clk), .reset(rst[1]), .send_en(send_en[1]), .cmd_index(idx[1]),
        .argument(arg[1]), .sd_cmd_out(out[1]), .sd_cmd_oe(oe[1]),
        .busy(busy[1]), .sd_send_finished(fin[1]));

    task automatic check(input bit ok, input string name, input logic [47:0] act,
                         input logic [47:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference CRC7 as polynomial long division of M(x)*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic monitor(input int k, input int div);
        logic [47:0] fr;
        logic [47:0] exp;
        logic        bitv;
        bit          stable;
        bit          gap_ok;
        bit          empty;
        int          n;
        int          g;
        forever begin
            @(negedge clk);
            if (!(rst[k] === 1'b1 && oe[k] === 1'b1)) continue;
            fr = '0; n = 0; stable = 1; bitv = 1'b0;
            while (oe[k] === 1'b1 && rst[k] === 1'b1 && n <= 48 * div) begin
                if (n % div == 0) begin
                    bitv = out[k];
                    fr   = {fr[46:0], out[k]};
                end else if (out[k] !== bitv) begin
                    stable = 0;
                end
                if (busy[k] !== 1'b1) stable = 0;
                n++;
                @(negedge clk);
            end
            if (rst[k] !== 1'b1) continue;
            check(n == 48 * div, "oe_length", 48'(n), 48'(48 * div));
            check(stable, "bit_hold", 48'(stable), 48'd1);
            g = 0; gap_ok = 1;
            while (fin[k] !== 1'b1 && rst[k] === 1'b1 && g < NCC * div + 4) begin
                if (oe[k] !== 1'b0 || out[k] !== 1'b1 || busy[k] !== 1'b1) gap_ok = 0;
                g++;
                @(negedge clk);
            end
            if (rst[k] !== 1'b1) continue;
            if (oe[k] !== 1'b0 || out[k] !== 1'b1 || busy[k] !== 1'b1) gap_ok = 0;
            check(gap_ok, "gap_line", 48'(gap_ok), 48'd1);
            check(fin[k] === 1'b1 && g == NCC * div - 1, "finished_time", 48'(g),
                  48'(NCC * div - 1));
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check(0, "unexpected_frame", fr, 48'd0);
            end else begin
                exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                check(fr === exp, "frame", fr, exp);
            end
            @(negedge clk);
            if (rst[k] !== 1'b1) continue;
            check(busy[k] === 1'b0 && fin[k] === 1'b0, "busy_drop",
                  48'({busy[k], fin[k]}), 48'd0);
        end
    endtask

    initial monitor(0, 2);
    initial monitor(1, 1);

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        @(negedge clk);
        while (busy[k] !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(busy[k] === 1'b0, "idle_wait", 48'(busy[k]), 48'd0);
    endtask

    task automatic send(input int k, input logic [5:0] ci, input logic [31:0] a,
                        input logic [47:0] e, input bit push);
        wait_idle(k);
        if (push) begin
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        idx[k] = ci;
        arg[k] = a;
        send_en[k] = 1'b1;
        @(posedge clk);
        #1 send_en[k] = 1'b0;
        @(negedge clk);
        check({busy[k], oe[k], out[k]} === 3'b110, "first_bit",
              48'({busy[k], oe[k], out[k]}), 48'h6);
    endtask

    initial begin
        logic [5:0]  ci;
        logic [31:0] a;
        logic [39:0] m;
        int seen;

        rst = 2'b00; send_en = 2'b00;
        idx[0] = '0; idx[1] = '0; arg[0] = '0; arg[1] = '0;
        #12;
        for (int k = 0; k < 2; k++)
            check({out[k], oe[k], busy[k], fin[k]} === 4'b1000, "reset_state",
                  48'({out[k], oe[k], busy[k], fin[k]}), 48'h8);
        repeat (3) @(negedge clk);
        rst = 2'b11;

        send(0, 6'd0, 32'h0, 48'h400000000095, 1);
        send(1, 6'd8, 32'h000001AA, 48'h48000001AA87, 1);

        // Inputs and a stray send_en mid-frame must not disturb the frame in flight.
        send(0, 6'd17, 32'h0, 48'h510000000055, 1);
        repeat (30) @(negedge clk);
        idx[0] = 6'h3F; arg[0] = 32'hFFFFFFFF; send_en[0] = 1'b1;
        repeat (4) @(negedge clk);
        send_en[0] = 1'b0;

        // Held send_en over 200 edges yields accepts at edge 0 and edge 113 only.
        wait_idle(0);
        idx[0] = '0; arg[0] = '0;
        q0.push_back(48'h400000000095);
        q0.push_back(48'h400000000095);
        send_en[0] = 1'b1;
        repeat (200) @(negedge clk);
        send_en[0] = 1'b0;

        // Abort at frame bit 20.
        send(0, 6'd0, 32'h0, 48'h0, 0);
        repeat (40) @(negedge clk);
        #2 rst[0] = 1'b0;
        #1 check({busy[0], oe[0], out[0], fin[0]} === 4'b0010, "abort_outputs",
                 48'({busy[0], oe[0], out[0], fin[0]}), 48'h2);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (fin[0] !== 1'b0 || oe[0] !== 1'b0) seen++;
        end
        check(seen == 0, "no_finish_after_abort", 48'(seen), 48'd0);
        send(0, 6'd0, 32'h0, 48'h400000000095, 1);

        for (int i = 0; i < 500; i++) begin
            ci = 6'($urandom);
            a  = $urandom;
            m  = {2'b01, ci, a};
            send(1, ci, a, {m, crc7(m), 1'b1}, 1);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (5) @(negedge clk);
        check(q0.size() == 0 && q1.size() == 0, "queue_drain",
              48'(q0.size() + q1.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end
endmodule
